// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_if
// Brief    : FIFO-drain and serial-side signal bundle for fifo_uart_tx.
// Revision : 1.0
// ============================================================================
interface fifo_uart_tx_if;
    logic        i_enable;
    logic        i_fifo_empty;
    logic [7:0]  i_fifo_data;
    logic        o_fifo_rd;
    logic        o_tx;
    logic        o_busy;
    logic        o_tx_done;
    logic [15:0] o_bytes_sent;

    // slave = the UART drain block, master = the FIFO/control side
    modport slave (
        input  i_enable, i_fifo_empty, i_fifo_data,
        output o_fifo_rd, o_tx, o_busy, o_tx_done, o_bytes_sent
    );

    modport master (
        output i_enable, i_fifo_empty, i_fifo_data,
        input  o_fifo_rd, o_tx, o_busy, o_tx_done, o_bytes_sent
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from a synchronous FIFO and sends them as 8N1 frames.
// Revision : 1.0
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fifo_uart_tx_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t           r_state,  w_state_nx;
    logic             r_tx,     w_tx_nx;
    logic             r_rd,     w_rd_nx;
    logic             r_busy;
    logic             r_done,   w_done_nx;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [2:0]       r_bit,    w_bit_nx;
    logic [7:0]       r_shift,  w_shift_nx;
    logic [15:0]      r_bytes,  w_bytes_nx;
    logic             w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_bytes <= 16'd0;
        end else begin
            r_state <= w_state_nx;
            r_tx    <= w_tx_nx;
            r_rd    <= w_rd_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_done_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_bytes <= w_bytes_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tx_nx    = r_tx;
        w_rd_nx    = 1'b0;
        w_done_nx  = 1'b0;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_bytes_nx = r_bytes;

        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (bus.i_enable && !bus.i_fifo_empty) begin
                    w_rd_nx    = 1'b1;
                    w_state_nx = S_POP;
                end
            end
            // FIFO registers its data_out on this edge; capture it next cycle
            S_POP: begin
                w_state_nx = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nx = bus.i_fifo_data;
                w_tx_nx    = 1'b0;
                w_cnt_nx   = '0;
                w_bit_nx   = 3'd0;
                w_state_nx = S_START;
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_tx_nx    = r_shift[0];
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nx = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
                    end else begin
                        // bit 0 of the shifter always mirrors the line
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                        w_bit_nx   = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b1;
                    w_bytes_nx = r_bytes + 16'd1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.o_fifo_rd    = r_rd;
    assign bus.o_tx         = r_tx;
    assign bus.o_busy       = r_busy;
    assign bus.o_tx_done    = r_done;
    assign bus.o_bytes_sent = r_bytes;
endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed self-checking bench for fifo_uart_tx with a FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vecs  = 0;
    int   errs  = 0;
    int   cyc   = 0;
    int   rd_cnt   = 0;
    int   done_cnt = 0;

    fifo_uart_tx_if bus();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // 31-entry FIFO model: registered data_out, flag updated on the pop edge
    logic [7:0] fifo_q[$];
    logic [7:0] fifo_dout  = 8'd0;
    logic       fifo_empty = 1'b1;
    int         fifo_cnt   = 0;
    logic       wr_en      = 1'b0;
    logic [7:0] wr_data    = 8'd0;

    always @(posedge clk) begin
        if (bus.o_fifo_rd && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        if (wr_en && fifo_q.size() < 31) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
        fifo_cnt   <= fifo_q.size();
    end

    assign bus.i_fifo_data  = fifo_dout;
    assign bus.i_fifo_empty = fifo_empty;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.o_fifo_rd) rd_cnt++;
        if (bus.o_tx_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rd(output int t);
        int n = 0;
        while (bus.o_fifo_rd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rd_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic wait_fall(output int t);
        int n = 0;
        while (bus.o_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("fall_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    // Called on the first negedge of the start bit; returns one cycle past the stop bit.
    task automatic check_frame(input logic [7:0] b);
        logic e;
        for (int i = 0; i < FRAME; i++) begin
            if (i < CPB)           e = 1'b0;
            else if (i < 9 * CPB)  e = b[(i - CPB) / CPB];
            else                   e = 1'b1;
            chk("frame_bit", {31'd0, bus.o_tx}, {31'd0, e});
            @(negedge clk);
        end
    endtask

    initial begin
        int t_rd, t1, t2, t3, rd0, dn0, by0;
        logic saw_low, saw_rd, saw_busy;
        logic [7:0] v;

        bus.i_enable = 1'b0;

        // asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx",    {31'd0, bus.o_tx},      32'd1);
        chk("rst_rd",    {31'd0, bus.o_fifo_rd}, 32'd0);
        chk("rst_busy",  {31'd0, bus.o_busy},    32'd0);
        chk("rst_done",  {31'd0, bus.o_tx_done}, 32'd0);
        chk("rst_bytes", {16'd0, bus.o_bytes_sent}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // empty FIFO with enable high: nothing happens
        bus.i_enable = 1'b1;
        saw_low = 0; saw_rd = 0; saw_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1)   saw_low  = 1;
            if (bus.o_fifo_rd)       saw_rd   = 1;
            if (bus.o_busy)          saw_busy = 1;
        end
        chk("empty_tx",   {31'd0, saw_low},  32'd0);
        chk("empty_rd",   {31'd0, saw_rd},   32'd0);
        chk("empty_busy", {31'd0, saw_busy}, 32'd0);

        // single byte 0xA5
        rd0 = rd_cnt; dn0 = done_cnt;
        push(8'hA5);
        wait_rd(t_rd);
        chk("a5_busy", {31'd0, bus.o_busy}, 32'd1);
        wait_fall(t1);
        chk("a5_latency", t1 - t_rd, 32'd2);
        check_frame(8'hA5);
        chk("a5_done",  {31'd0, bus.o_tx_done}, 32'd1);
        chk("a5_idle",  {31'd0, bus.o_busy},    32'd0);
        chk("a5_bytes", {16'd0, bus.o_bytes_sent}, 32'd1);
        @(negedge clk);
        chk("a5_done_pulse", {31'd0, bus.o_tx_done}, 32'd0);
        chk("a5_rd_pulses",   rd_cnt - rd0,   32'd1);
        chk("a5_done_pulses", done_cnt - dn0, 32'd1);

        // burst of three bytes, 43-cycle frame pitch
        rd0 = rd_cnt;
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_fall(t1);
        check_frame(8'h00);
        wait_fall(t2);
        chk("burst_gap1", t2 - t1, FRAME + 3);
        check_frame(8'hFF);
        wait_fall(t3);
        chk("burst_gap2", t3 - t2, FRAME + 3);
        check_frame(8'h3C);
        chk("burst_bytes", {16'd0, bus.o_bytes_sent}, 32'd4);
        chk("burst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("burst_rd",    rd_cnt - rd0, 32'd3);

        // reset asserted mid-DATA (0x81, bit 1 is low on the line)
        push(8'h81);
        wait_rd(t_rd);
        repeat (12) @(negedge clk);
        chk("mid_tx_low", {31'd0, bus.o_tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",    {31'd0, bus.o_tx},      32'd1);
        chk("mid_rst_busy",  {31'd0, bus.o_busy},    32'd0);
        chk("mid_rst_rd",    {31'd0, bus.o_fifo_rd}, 32'd0);
        chk("mid_rst_bytes", {16'd0, bus.o_bytes_sent}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_cnt; saw_low = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1) saw_low = 1;
        end
        chk("post_rst_tx", {31'd0, saw_low}, 32'd0);
        chk("post_rst_rd", rd_cnt - rd0, 32'd0);

        // enable dropped during the start bit with a second byte queued
        rd0 = rd_cnt;
        push(8'h55); push(8'h66);
        wait_fall(t1);
        bus.i_enable = 1'b0;
        check_frame(8'h55);
        chk("en_bytes", {16'd0, bus.o_bytes_sent}, 32'd1);
        repeat (60) @(negedge clk);
        chk("en_rd",    rd_cnt - rd0, 32'd1);
        chk("en_empty", {31'd0, fifo_empty}, 32'd0);
        chk("en_level", fifo_cnt, 32'd1);
        chk("en_busy",  {31'd0, bus.o_busy}, 32'd0);
        bus.i_enable = 1'b1;
        wait_fall(t1);
        check_frame(8'h66);
        chk("en_bytes2", {16'd0, bus.o_bytes_sent}, 32'd2);

        // fill to 31 entries, then drain everything in order
        bus.i_enable = 1'b0;
        for (int i = 0; i < 31; i++) push(8'(i * 7 + 3));
        @(negedge clk);
        chk("fill_level", fifo_cnt, 32'd31);
        rd0 = rd_cnt; dn0 = done_cnt; by0 = int'(bus.o_bytes_sent);
        bus.i_enable = 1'b1;
        for (int i = 0; i < 31; i++) begin
            v = 8'(i * 7 + 3);
            wait_fall(t1);
            check_frame(v);
        end
        repeat (4) @(negedge clk);
        chk("fill_bytes", int'(bus.o_bytes_sent) - by0, 32'd31);
        chk("fill_rd",    rd_cnt - rd0,   32'd31);
        chk("fill_done",  done_cnt - dn0, 32'd31);
        chk("fill_empty", {31'd0, fifo_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire
